// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetched instruction records, resolved
// oldest-first against execute outcomes. It drives predictor updates and
// mispredict flush/redirect, and keeps statistics and sticky error flags.
module branch_resolve_unit #(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_valid,
    input  logic [31:0] push_pc,
    input  logic        push_bp,
    input  logic [31:0] push_target,
    output logic        push_ready,
    input  logic        res_valid,
    input  logic        res_is_branch,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        BranchB,
    output logic        ZeroB,
    output logic [31:0] PCB,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [15:0] br_count,
    output logic [15:0] mp_count,
    output logic        underflow_err,
    output logic        overflow_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

    logic [31:0] pc_mem  [DEPTH];
    logic        bp_mem  [DEPTH];
    logic [31:0] tgt_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [CW-1:0]         count;

    logic        empty;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic [31:0] head_pc;
    logic [31:0] seq_pc;
    logic [31:0] pred_pc;
    logic [31:0] actual_pc;
    logic        mispredict;

    // Head record decode and predicted-vs-actual next-PC comparison
    always_comb begin
        empty      = (count == '0);
        full       = (count == CNT_FULL);
        pop        = res_valid && !empty;
        push_ready = !full || (res_valid && !empty);
        push_ok    = push_valid && push_ready;
        head_pc    = pc_mem[head];
        seq_pc     = head_pc + 32'd4;
        pred_pc    = bp_mem[head] ? tgt_mem[head] : seq_pc;
        actual_pc  = (res_is_branch && res_taken) ? res_target : seq_pc;
        mispredict = pop && (pred_pc != actual_pc);
    end

    // Record storage; a push coinciding with a mispredict is wrong-path and dropped
    always_ff @(posedge clk) begin
        if (push_ok && !mispredict) begin
            pc_mem[tail]  <= push_pc;
            bp_mem[tail]  <= push_bp;
            tgt_mem[tail] <= push_target;
        end
    end

    // Queue pointers and occupancy; mispredict discards every in-flight record
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + PTR_ONE;
            if (pop)     head <= head + PTR_ONE;
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    // Predictor update, flush/redirect, statistics and sticky error flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            BranchB       <= 1'b0;
            ZeroB         <= 1'b0;
            PCB           <= '0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            br_count      <= '0;
            mp_count      <= '0;
            underflow_err <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            BranchB <= pop && res_is_branch;
            ZeroB   <= pop && res_is_branch && res_taken;
            flush   <= mispredict;
            if (pop && res_is_branch) begin
                PCB <= head_pc;
                if (br_count != 16'hFFFF) br_count <= br_count + 16'd1;
            end
            if (mispredict) begin
                redirect_pc <= actual_pc;
                if (mp_count != 16'hFFFF) mp_count <= mp_count + 16'd1;
            end
            if (res_valid && empty)      underflow_err <= 1'b1;
            if (push_valid && !push_ready) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios with literal
// expectations plus a queue-based reference model compared every cycle.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_bp;
    logic [31:0] push_target;
    logic        push_ready;
    logic        res_valid;
    logic        res_is_branch;
    logic        res_taken;
    logic [31:0] res_target;
    logic        BranchB;
    logic        ZeroB;
    logic [31:0] PCB;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] br_count;
    logic [15:0] mp_count;
    logic        underflow_err;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.DEPTH_LOG2(2)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_pc(push_pc), .push_bp(push_bp),
        .push_target(push_target), .push_ready(push_ready),
        .res_valid(res_valid), .res_is_branch(res_is_branch),
        .res_taken(res_taken), .res_target(res_target),
        .BranchB(BranchB), .ZeroB(ZeroB), .PCB(PCB), .flush(flush),
        .redirect_pc(redirect_pc), .br_count(br_count), .mp_count(mp_count),
        .underflow_err(underflow_err), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of records, resolved oldest-first
    typedef struct packed {
        logic [31:0] pc;
        logic        bp;
        logic [31:0] tgt;
    } rec_t;

    rec_t        mq[$];
    bit          model_live = 0;
    logic        m_branchb, m_zerob, m_flush, m_under, m_over;
    logic [31:0] m_pcb, m_redirect;
    logic [15:0] m_br, m_mp;

    initial begin
        rec_t        h;
        logic [31:0] pred, act;
        bit          rdy;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mq.delete();
                {m_branchb, m_zerob, m_flush, m_under, m_over} = '0;
                m_pcb = '0; m_redirect = '0; m_br = '0; m_mp = '0;
                model_live = 1;
            end else if (model_live) begin
                rdy = (mq.size() < DEPTH) || (res_valid && mq.size() > 0);
                m_branchb = 0; m_zerob = 0; m_flush = 0;
                if (push_valid && !rdy) m_over = 1;
                if (res_valid && mq.size() > 0) begin
                    h    = mq.pop_front();
                    pred = h.bp ? h.tgt : h.pc + 32'd4;
                    act  = (res_is_branch && res_taken) ? res_target : h.pc + 32'd4;
                    if (res_is_branch) begin
                        m_branchb = 1;
                        m_zerob   = res_taken;
                        m_pcb     = h.pc;
                        if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
                    end
                    if (pred != act) begin
                        m_flush    = 1;
                        m_redirect = act;
                        if (m_mp != 16'hFFFF) m_mp = m_mp + 16'd1;
                        mq.delete();
                    end else if (push_valid) begin
                        mq.push_back('{push_pc, push_bp, push_target});
                    end
                end else begin
                    if (res_valid) m_under = 1;
                    if (push_valid && rdy) mq.push_back('{push_pc, push_bp, push_target});
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (model_live) begin
                check("push_ready", 32'(push_ready),
                      32'((mq.size() < DEPTH) || (res_valid && mq.size() > 0)));
                check("BranchB", 32'(BranchB), 32'(m_branchb));
                check("ZeroB", 32'(ZeroB), 32'(m_zerob));
                check("PCB", PCB, m_pcb);
                check("flush", 32'(flush), 32'(m_flush));
                check("redirect_pc", redirect_pc, m_redirect);
                check("br_count", 32'(br_count), 32'(m_br));
                check("mp_count", 32'(mp_count), 32'(m_mp));
                check("underflow_err", 32'(underflow_err), 32'(m_under));
                check("overflow_err", 32'(overflow_err), 32'(m_over));
            end
        end
    end

    // Apply one cycle of inputs (called at a negedge) and wait for the next negedge
    task automatic tick(input logic rst, input logic pv, input logic [31:0] pc,
                        input logic bp, input logic [31:0] tgt, input logic rv,
                        input logic isb, input logic tk, input logic [31:0] rt);
        reset = rst; push_valid = pv; push_pc = pc; push_bp = bp; push_target = tgt;
        res_valid = rv; res_is_branch = isb; res_taken = tk; res_target = rt;
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic bp, input logic [31:0] tgt);
        tick(1, 1, pc, bp, tgt, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic isb, input logic tk, input logic [31:0] rt);
        tick(1, 0, 0, 0, 0, 1, isb, tk, rt);
    endtask

    initial begin
        reset = 0; push_valid = 0; push_pc = 0; push_bp = 0; push_target = 0;
        res_valid = 0; res_is_branch = 0; res_taken = 0; res_target = 0;
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_BranchB", 32'(BranchB), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_br_count", 32'(br_count), 0);
        check("rst_PCB", PCB, 0);
        idle();
        check("ready_after_reset", 32'(push_ready), 1);

        // Resolve on an empty queue
        resolve(1, 1, 32'h40);
        check("uf_err", 32'(underflow_err), 1);
        check("uf_BranchB", 32'(BranchB), 0);
        check("uf_flush", 32'(flush), 0);

        // Correctly predicted not-taken branch
        push(32'h100, 0, 0);
        resolve(1, 0, 32'h180);
        check("nt_BranchB", 32'(BranchB), 1);
        check("nt_ZeroB", 32'(ZeroB), 0);
        check("nt_PCB", PCB, 32'h100);
        check("nt_flush", 32'(flush), 0);
        check("nt_br_count", 32'(br_count), 1);

        // Mispredicted taken branch flushes younger record and same-cycle push
        push(32'h200, 0, 0);
        push(32'h204, 0, 0);
        tick(1, 1, 32'h208, 0, 0, 1, 1, 1, 32'h240);
        check("mp_flush", 32'(flush), 1);
        check("mp_redirect", redirect_pc, 32'h240);
        check("mp_count", 32'(mp_count), 1);
        check("mp_ZeroB", 32'(ZeroB), 1);
        check("mp_PCB", PCB, 32'h200);
        idle();
        check("mp_flush_one_cycle", 32'(flush), 0);
        check("mp_redirect_hold", redirect_pc, 32'h240);
        resolve(1, 0, 0);
        check("mp_queue_empty", 32'(BranchB), 0);

        // Aliased prediction on a non-branch
        push(32'h300, 1, 32'h380);
        resolve(0, 0, 0);
        check("alias_flush", 32'(flush), 1);
        check("alias_redirect", redirect_pc, 32'h304);
        check("alias_BranchB", 32'(BranchB), 0);
        check("alias_PCB_hold", PCB, 32'h200);
        check("alias_mp_count", 32'(mp_count), 2);

        // Fill, overflow, push+pop while full, then drain across the wrap
        push(32'h400, 0, 0);
        push(32'h404, 0, 0);
        push(32'h408, 0, 0);
        push(32'h40C, 0, 0);
        check("full_ready", 32'(push_ready), 0);
        check("full_no_ovf", 32'(overflow_err), 0);
        push(32'h410, 0, 0);
        check("ovf_err", 32'(overflow_err), 1);
        tick(1, 1, 32'h414, 0, 0, 1, 0, 0, 0);
        check("full_pushpop_flush", 32'(flush), 0);
        idle();
        check("still_full", 32'(push_ready), 0);
        resolve(1, 0, 0);
        check("drain_PCB0", PCB, 32'h404);
        resolve(1, 0, 0);
        check("drain_PCB1", PCB, 32'h408);
        resolve(1, 0, 0);
        check("drain_PCB2", PCB, 32'h40C);
        resolve(1, 0, 0);
        check("drain_PCB3", PCB, 32'h414);
        check("drain_br_count", 32'(br_count), 6);

        // Reset overrides in-flight work and a same-cycle pop/push
        push(32'h500, 0, 0);
        push(32'h504, 0, 0);
        push(32'h508, 1, 32'h600);
        tick(0, 1, 32'h50C, 0, 0, 1, 1, 1, 32'h700);
        check("midrst_BranchB", 32'(BranchB), 0);
        check("midrst_flush", 32'(flush), 0);
        check("midrst_redirect", redirect_pc, 0);
        check("midrst_mp", 32'(mp_count), 0);
        check("midrst_ovf", 32'(overflow_err), 0);
        idle();
        check("postrst_flush", 32'(flush), 0);
        resolve(1, 0, 0);
        check("postrst_empty", 32'(BranchB), 0);
        check("postrst_uf", 32'(underflow_err), 1);

        // Mixed traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, tg, rt;
            pc = 32'({$urandom_range(0, 7), 2'b00});
            tg = 32'({$urandom_range(0, 7), 2'b00});
            rt = 32'({$urandom_range(0, 7), 2'b00});
            tick(($urandom_range(0, 60) != 0), 1'($urandom), pc, 1'($urandom), tg,
                 1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom), rt);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
